// File: rtl/qacc_stream_pkg.sv
// Shared Q-format fixed-point definitions for the accumulator datapath.
package qfx_pkg;

    localparam int unsigned QFX_N = 20;
    localparam int unsigned QFX_Q = 11;

    localparam logic [QFX_N-1:0] QMAX = {1'b0, {(QFX_N-1){1'b1}}};
    localparam logic [QFX_N-1:0] QMIN = {1'b1, {(QFX_N-1){1'b0}}};

    typedef logic signed [QFX_N-1:0] qfx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } acc_state_t;

endpackage

// File: rtl/qacc_stream_if.sv
// Term stream in, result stream out, plus the per-vector bias preload.
interface qacc_stream_if
    import qfx_pkg::*;
#(
    parameter int unsigned N     = QFX_N,
    parameter int unsigned CNT_W = 10
);
    logic signed [N-1:0] bias;
    logic                s_valid;
    logic                s_ready;
    logic signed [N-1:0] s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic signed [N-1:0] m_data;
    logic                m_sat;
    logic [CNT_W-1:0]    m_count;

    // Upstream source / downstream sink side.
    modport master (
        output bias, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_sat, m_count
    );

    // Accumulator side.
    modport slave (
        input  bias, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_sat, m_count
    );
endinterface

// File: rtl/qacc_stream_qadd.sv
// Saturating two's-complement adder: clamps to the most positive / most
// negative code when the true sum does not fit in W bits.
module qadd #(
    parameter int unsigned W = 20
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum
);
    logic [W:0] w_wide;
    logic       w_ovf;

    // Overflow only when both operands share a sign and the result flips it.
    always_comb begin
        w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        w_ovf  = (i_a[W-1] == i_b[W-1]) && (w_wide[W-1] != i_a[W-1]);
        if (w_ovf) begin
            o_sum = i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            o_sum = w_wide[W-1:0];
        end
    end
endmodule

// File: rtl/qacc_stream.sv
// Streaming saturating accumulator: sums one signed term per beat onto a
// preloaded bias and emits one result per vector on the last beat.
module qacc_stream
    import qfx_pkg::*;
#(
    parameter int unsigned N     = QFX_N,
    parameter int unsigned Q     = QFX_Q,
    parameter int unsigned CNT_W = 10
) (
    input  logic clk,
    input  logic rst_n,
    qacc_stream_if.slave bus
);
    // Q only documents the format; the sum itself is format-agnostic.
    if (Q >= N) begin : g_q_exceeds_width
    end

    acc_state_t          r_state;
    logic signed [N-1:0] r_acc;
    logic                r_sat;
    logic [CNT_W-1:0]    r_count;
    logic                r_s_ready;
    logic                r_m_valid;

    logic signed [N-1:0] w_a;
    logic signed [N-1:0] w_sum;
    logic [N-1:0]        w_raw;
    logic                w_ovf;
    logic                w_accept;

    // First beat of a vector adds onto bias, later beats onto the running sum.
    always_comb begin
        w_a      = (r_state == IDLE) ? bus.bias : r_acc;
        w_raw    = w_a + bus.s_data;
        w_ovf    = (w_a[N-1] == bus.s_data[N-1]) && (w_raw[N-1] != w_a[N-1]);
        w_accept = bus.s_valid && r_s_ready;
    end

    qadd #(
        .W (N)
    ) u_qadd (
        .i_a   (w_a),
        .i_b   (bus.s_data),
        .o_sum (w_sum)
    );

    // Vector FSM; all stream outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_count   <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, ACCUM: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_sum;
                        if (r_state == IDLE) begin
                            r_count <= CNT_W'(1);
                            r_sat   <= w_ovf;
                        end else begin
                            if (r_count != {CNT_W{1'b1}}) begin
                                r_count <= r_count + CNT_W'(1);
                            end
                            r_sat <= r_sat | w_ovf;
                        end
                        if (bus.s_last) begin
                            r_state   <= OUT;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        r_state   <= IDLE;
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_acc;
    assign bus.m_sat   = r_sat;
    assign bus.m_count = r_count;
endmodule

// File: tb/tb_qacc_stream.sv
// Directed bench for qacc_stream: a table of beats with hand-computed
// results, plus sequences for backpressure, back-to-back, count saturation
// and mid-vector reset.
module tb_qacc_stream;
    logic clk = 1'b0;
    logic rst_n;

    qacc_stream_if #(.N(20), .CNT_W(10)) bus ();

    qacc_stream #(.N(20), .Q(11), .CNT_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bias;
        logic [19:0] data;
        logic        last;
        logic [19:0] exp_data;
        logic        exp_sat;
        logic [9:0]  exp_count;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; presents one beat and lets it be taken.
    task automatic beat(input logic [19:0] b, input logic [19:0] d, input logic l);
        bus.bias    = b;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        chk("s_ready_before_beat", {19'd0, bus.s_ready}, 20'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic pop();
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        chk("m_valid_after_pop", {19'd0, bus.m_valid}, 20'd0);
        chk("s_ready_after_pop", {19'd0, bus.s_ready}, 20'd1);
    endtask

    initial begin
        logic [19:0] exp_v;
        int          k;

        rst_n       = 1'b0;
        bus.bias    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Vectors; bias on non-first beats is junk that must be ignored.
        tbl.push_back('{20'h00000, 20'h00800, 1'b0, 20'h0, 1'b0, 10'd0});
        tbl.push_back('{20'h12345, 20'h00800, 1'b0, 20'h0, 1'b0, 10'd0});
        tbl.push_back('{20'h12345, 20'h00400, 1'b1, 20'h01400, 1'b0, 10'd3});
        tbl.push_back('{20'h7F000, 20'h01000, 1'b0, 20'h0, 1'b0, 10'd0});
        tbl.push_back('{20'h00000, 20'hFF800, 1'b1, 20'h7F7FF, 1'b1, 10'd2});
        tbl.push_back('{20'h80000, 20'hFF800, 1'b1, 20'h80000, 1'b1, 10'd1});
        tbl.push_back('{20'h00000, 20'h00800, 1'b1, 20'h00800, 1'b0, 10'd1});
        tbl.push_back('{20'h7FFFF, 20'h80000, 1'b1, 20'hFFFFF, 1'b0, 10'd1});
        tbl.push_back('{20'hFFC00, 20'hFFC00, 1'b1, 20'hFF800, 1'b0, 10'd1});
        tbl.push_back('{20'h70000, 20'h10000, 1'b0, 20'h0, 1'b0, 10'd0});
        tbl.push_back('{20'h55555, 20'h10000, 1'b0, 20'h0, 1'b0, 10'd0});
        tbl.push_back('{20'h55555, 20'hE0001, 1'b1, 20'h60000, 1'b1, 10'd3});

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {19'd0, bus.m_valid}, 20'd0);
        chk("rst_s_ready", {19'd0, bus.s_ready}, 20'd0);
        chk("rst_m_data",  bus.m_data, 20'd0);
        chk("rst_m_sat",   {19'd0, bus.m_sat}, 20'd0);
        chk("rst_m_count", {10'd0, bus.m_count}, 20'd0);
        rst_n = 1'b1;
        #1;
        chk("s_ready_at_release", {19'd0, bus.s_ready}, 20'd0);
        @(posedge clk);
        #1;
        chk("s_ready_after_release", {19'd0, bus.s_ready}, 20'd1);

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].bias, tbl[i].data, tbl[i].last);
            chk($sformatf("v%0d_m_valid", i), {19'd0, bus.m_valid}, {19'd0, tbl[i].last});
            if (tbl[i].last) begin
                chk($sformatf("v%0d_m_data", i), bus.m_data, tbl[i].exp_data);
                chk($sformatf("v%0d_m_sat", i), {19'd0, bus.m_sat}, {19'd0, tbl[i].exp_sat});
                chk($sformatf("v%0d_m_count", i), {10'd0, bus.m_count}, {10'd0, tbl[i].exp_count});
                pop();
            end
        end

        // Backpressure: result held while a new beat waits upstream.
        beat(20'h00010, 20'h00020, 1'b1);
        bus.bias    = 20'h00000;
        bus.s_data  = 20'h00005;
        bus.s_last  = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_m_valid", {19'd0, bus.m_valid}, 20'd1);
            chk("bp_m_data", bus.m_data, 20'h00030);
            chk("bp_m_sat", {19'd0, bus.m_sat}, 20'd0);
            chk("bp_m_count", {10'd0, bus.m_count}, 20'd1);
            chk("bp_s_ready", {19'd0, bus.s_ready}, 20'd0);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        chk("bp_release_m_valid", {19'd0, bus.m_valid}, 20'd0);
        chk("bp_release_s_ready", {19'd0, bus.s_ready}, 20'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("bp_held_m_valid", {19'd0, bus.m_valid}, 20'd1);
        chk("bp_held_m_data", bus.m_data, 20'h00005);
        chk("bp_held_m_count", {10'd0, bus.m_count}, 20'd1);
        pop();

        // Back-to-back single-beat vectors: a result every other cycle.
        k           = 0;
        bus.bias    = 20'h00100;
        bus.s_data  = 20'h00010;
        bus.s_last  = 1'b1;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_m_valid", {19'd0, bus.m_valid}, (i % 2 == 0) ? 20'd1 : 20'd0);
            if (bus.m_valid) begin
                exp_v = 20'h00110 + 20'(k * 'h40);
                chk("b2b_m_data", bus.m_data, exp_v);
                k++;
                bus.s_data = 20'h00010 + 20'(k * 'h40);
            end
        end
        chk("b2b_results", 20'(k), 20'd5);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;

        // Beat counter saturates at all-ones instead of wrapping.
        bus.bias    = 20'h00400;
        bus.s_data  = 20'h00000;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            bus.s_last = (i == 1029);
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("cnt_m_valid", {19'd0, bus.m_valid}, 20'd1);
        chk("cnt_m_count", {10'd0, bus.m_count}, 20'h003FF);
        chk("cnt_m_data", bus.m_data, 20'h00400);
        pop();

        // Reset in the middle of a vector discards the partial sum.
        beat(20'h00000, 20'h00800, 1'b0);
        beat(20'h00000, 20'h00800, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", {19'd0, bus.m_valid}, 20'd0);
        chk("mid_rst_s_ready", {19'd0, bus.s_ready}, 20'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_s_ready", {19'd0, bus.s_ready}, 20'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(20'h00000, 20'h00400, 1'b1);
        chk("post_rst_m_valid", {19'd0, bus.m_valid}, 20'd1);
        chk("post_rst_m_data", bus.m_data, 20'h00400);
        chk("post_rst_m_count", {10'd0, bus.m_count}, 20'd1);
        chk("post_rst_m_sat", {19'd0, bus.m_sat}, 20'd0);
        pop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
